// File: rtl/hex_display_buffer_if.sv
// hex_display_buffer_if
// Bundles the command, read-back and display signals of hex_display_buffer.
//   master : the controller side (keyboard decoder, test bench) that drives
//            commands and observes the buffer state.
//   slave  : the buffer itself.
// Signals:
//   wr_en/wr_addr/wr_data  direct addressed write
//   push/push_data         append at cursor
//   backspace              retreat cursor and zero that entry
//   clear                  start the clear sweep
//   rd_addr/rd_data        registered read-back port
//   cursor/full/overflow/busy  status
//   hex                    flat view of the whole buffer
interface hex_display_buffer_if #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3
);
    logic                        wr_en;
    logic [ADDR_WIDTH-1:0]       wr_addr;
    logic [DATA_WIDTH-1:0]       wr_data;
    logic                        push;
    logic [DATA_WIDTH-1:0]       push_data;
    logic                        backspace;
    logic                        clear;
    logic [ADDR_WIDTH-1:0]       rd_addr;
    logic [DATA_WIDTH-1:0]       rd_data;
    logic [ADDR_WIDTH:0]         cursor;
    logic                        full;
    logic                        overflow;
    logic                        busy;
    logic [DEPTH*DATA_WIDTH-1:0] hex;

    modport master (
        output wr_en, wr_addr, wr_data, push, push_data, backspace, clear, rd_addr,
        input  rd_data, cursor, full, overflow, busy, hex
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, push, push_data, backspace, clear, rd_addr,
        output rd_data, cursor, full, overflow, busy, hex
    );
endinterface

// File: rtl/hex_display_buffer.sv
// hex_display_buffer
// Byte-addressed display buffer feeding the seven-segment and VGA text overlay
// paths. Accepts direct addressed writes plus keyboard-style cursor entry
// (append, backspace) and a multi-cycle clear sweep that zeroes one entry per
// cycle. The full buffer is exposed flat on hex; rd_data is a registered
// read-back of a single entry.
// Ports:
//   clock  rising-edge system clock
//   reset  synchronous, active-high
//   bus    hex_display_buffer_if.slave (commands, read-back, status, hex)
module hex_display_buffer #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int WRAP       = 0
) (
    input logic              clock,
    input logic              reset,
    hex_display_buffer_if.slave bus
);
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0]         C_DEPTH  = CW'(DEPTH);
    localparam logic [CW-1:0]         C_LAST   = CW'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_CLEARING = 1'b1;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [0:0]            r_state;
    logic [ADDR_WIDTH-1:0] r_sweepIdx;
    logic [CW-1:0]         r_cursor;
    logic                  r_overflow;
    logic [DATA_WIDTH-1:0] r_rdData;

    logic                  w_idle;
    logic                  w_full;
    logic                  w_doClear;
    logic                  w_doWrite;
    logic                  w_doPush;
    logic                  w_doBack;
    logic                  w_wrInRange;
    logic [CW-1:0]         w_cursorDec;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_rdMux;

    assign w_idle      = (r_state == ST_IDLE);
    assign w_full      = (r_cursor == C_DEPTH);
    assign w_wrInRange = ({1'b0, bus.wr_addr} < C_DEPTH);
    assign w_cursorDec = r_cursor - CW'(1);

    // Only one command is honoured per cycle; the decode below encodes the
    // priority so lower strobes in the same cycle simply vanish.
    assign w_doClear = w_idle && bus.clear;
    assign w_doWrite = w_idle && !bus.clear && bus.wr_en;
    assign w_doPush  = w_idle && !bus.clear && !bus.wr_en && bus.push;
    assign w_doBack  = w_idle && !bus.clear && !bus.wr_en && !bus.push && bus.backspace;

    // Single shared write port: the sweep, direct writes, appends and
    // backspaces never happen together, so one address/data pair suffices.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = '0;
        w_wdata = '0;
        if (!w_idle) begin
            w_we    = 1'b1;
            w_waddr = r_sweepIdx;
        end else if (w_doWrite) begin
            w_we    = w_wrInRange;
            w_waddr = bus.wr_addr;
            w_wdata = bus.wr_data;
        end else if (w_doPush) begin
            w_we    = !w_full;
            w_waddr = r_cursor[ADDR_WIDTH-1:0];
            w_wdata = bus.push_data;
        end else if (w_doBack) begin
            if (r_cursor != '0) begin
                w_we    = 1'b1;
                w_waddr = w_cursorDec[ADDR_WIDTH-1:0];
            end else if (WRAP != 0) begin
                w_we    = 1'b1;
                w_waddr = LAST_IDX;
            end
        end
    end

    // Entry storage; compare-per-entry keeps non power-of-two depths safe.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_we && (w_waddr == ADDR_WIDTH'(i))) r_mem[i] <= w_wdata;
            end
        end
    end

    // Read-back mux; addresses past the end read as zero.
    always_comb begin
        w_rdMux = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (bus.rd_addr == ADDR_WIDTH'(i)) w_rdMux = r_mem[i];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) r_rdData <= '0;
        else       r_rdData <= w_rdMux;
    end

    // Clear sweep FSM: walks r_sweepIdx from 0 to DEPTH-1, one entry per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_sweepIdx <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_doClear) begin
                r_state    <= ST_CLEARING;
                r_sweepIdx <= '0;
            end
        end else begin
            if (r_sweepIdx == LAST_IDX) begin
                r_state    <= ST_IDLE;
                r_sweepIdx <= '0;
            end else begin
                r_sweepIdx <= r_sweepIdx + ADDR_WIDTH'(1);
            end
        end
    end

    // Cursor and sticky overflow. With WRAP=0 the cursor may rest at DEPTH,
    // which is what makes full true.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cursor   <= '0;
            r_overflow <= 1'b0;
        end else if (w_doClear) begin
            r_cursor   <= '0;
            r_overflow <= 1'b0;
        end else if (w_doPush) begin
            if (w_full)                                 r_overflow <= 1'b1;
            else if ((WRAP != 0) && (r_cursor == C_LAST)) r_cursor <= '0;
            else                                        r_cursor <= r_cursor + CW'(1);
        end else if (w_doBack) begin
            if (r_cursor != '0)  r_cursor <= w_cursorDec;
            else if (WRAP != 0)  r_cursor <= C_LAST;
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_hex
        assign bus.hex[g*DATA_WIDTH +: DATA_WIDTH] = r_mem[g];
    end

    assign bus.rd_data  = r_rdData;
    assign bus.cursor   = r_cursor;
    assign bus.full     = w_full;
    assign bus.overflow = r_overflow;
    assign bus.busy     = !w_idle;
endmodule

// File: tb/tb_hex_display_buffer.sv
// tb_hex_display_buffer
// Drives identical command streams into a saturating (WRAP=0) and a wrapping
// (WRAP=1) instance. A behavioural model predicts each instance's state after
// every edge; predictions are queued when the stimulus is applied and popped
// and compared once the edge has happened. A few hand-computed values anchor
// the model at key points.
module tb_hex_display_buffer;
    logic clock;
    logic reset;

    hex_display_buffer_if #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) if0 ();
    hex_display_buffer_if #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3)) if1 ();

    hex_display_buffer #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .WRAP(0)) dut0 (
        .clock (clock),
        .reset (reset),
        .bus   (if0)
    );

    hex_display_buffer #(.DATA_WIDTH(8), .DEPTH(8), .ADDR_WIDTH(3), .WRAP(1)) dut1 (
        .clock (clock),
        .reset (reset),
        .bus   (if1)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [63:0] hex;
        logic [3:0]  cursor;
        logic        full;
        logic        overflow;
        logic        busy;
        logic [7:0]  rd;
    } expRec_t;

    expRec_t expQ[$];
    int total = 0;
    int bad   = 0;

    // Model state, index 0 = WRAP=0 instance, index 1 = WRAP=1 instance
    logic [7:0] mMem [2][8];
    int         mCursor [2];
    logic       mOvf [2];
    logic       mBusy [2];
    int         mSweep [2];
    logic [7:0] mRd [2];

    // Current stimulus
    logic       sWrEn, sPush, sBack, sClear, sReset;
    logic [2:0] sWrAddr, sRdAddr;
    logic [7:0] sWrData, sPushData;

    // Counts a comparison and reports it when observed differs from expected.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Predicts one instance's state after the coming edge.
    task automatic modelStep(input int d);
        logic [7:0] rdNext;
        rdNext = mMem[d][sRdAddr];
        if (sReset) begin
            for (int i = 0; i < 8; i++) mMem[d][i] = 8'h00;
            mCursor[d] = 0;
            mOvf[d]    = 1'b0;
            mBusy[d]   = 1'b0;
            mSweep[d]  = 0;
            mRd[d]     = 8'h00;
            return;
        end
        mRd[d] = rdNext;
        if (mBusy[d]) begin
            mMem[d][mSweep[d]] = 8'h00;
            if (mSweep[d] == 7) mBusy[d] = 1'b0;
            mSweep[d]++;
        end else if (sClear) begin
            mBusy[d]   = 1'b1;
            mSweep[d]  = 0;
            mCursor[d] = 0;
            mOvf[d]    = 1'b0;
        end else if (sWrEn) begin
            mMem[d][sWrAddr] = sWrData;
        end else if (sPush) begin
            if (mCursor[d] == 8) begin
                mOvf[d] = 1'b1;
            end else begin
                mMem[d][mCursor[d]] = sPushData;
                if (d == 1 && mCursor[d] == 7) mCursor[d] = 0;
                else                           mCursor[d] = mCursor[d] + 1;
            end
        end else if (sBack) begin
            if (mCursor[d] > 0) begin
                mCursor[d] = mCursor[d] - 1;
                mMem[d][mCursor[d]] = 8'h00;
            end else if (d == 1) begin
                mCursor[d] = 7;
                mMem[d][7] = 8'h00;
            end
        end
    endtask

    function automatic expRec_t modelRec(input int d);
        expRec_t r;
        for (int i = 0; i < 8; i++) r.hex[i*8 +: 8] = mMem[d][i];
        r.cursor   = 4'(mCursor[d]);
        r.full     = (mCursor[d] == 8);
        r.overflow = mOvf[d];
        r.busy     = mBusy[d];
        r.rd       = mRd[d];
        return r;
    endfunction

    task automatic compareRec(input string pfx, input expRec_t o, input expRec_t e);
        checkOutput({pfx, "_hex"},      64'(o.hex),      64'(e.hex));
        checkOutput({pfx, "_cursor"},   64'(o.cursor),   64'(e.cursor));
        checkOutput({pfx, "_full"},     64'(o.full),     64'(e.full));
        checkOutput({pfx, "_overflow"}, 64'(o.overflow), 64'(e.overflow));
        checkOutput({pfx, "_busy"},     64'(o.busy),     64'(e.busy));
        checkOutput({pfx, "_rd_data"},  64'(o.rd),       64'(e.rd));
    endtask

    // Drives one cycle of stimulus into both instances, queues the predicted
    // results, waits for the edge and compares.
    task automatic applyStimulus(input logic wrEn, input logic [2:0] wrAddr, input logic [7:0] wrData,
                                 input logic push, input logic [7:0] pushData, input logic back,
                                 input logic clr, input logic [2:0] rdAddr, input logic rst);
        expRec_t o, e;
        sWrEn = wrEn; sWrAddr = wrAddr; sWrData = wrData;
        sPush = push; sPushData = pushData; sBack = back;
        sClear = clr; sRdAddr = rdAddr; sReset = rst;
        reset         = rst;
        if0.wr_en     = wrEn;  if1.wr_en     = wrEn;
        if0.wr_addr   = wrAddr; if1.wr_addr  = wrAddr;
        if0.wr_data   = wrData; if1.wr_data  = wrData;
        if0.push      = push;  if1.push      = push;
        if0.push_data = pushData; if1.push_data = pushData;
        if0.backspace = back;  if1.backspace = back;
        if0.clear     = clr;   if1.clear     = clr;
        if0.rd_addr   = rdAddr; if1.rd_addr  = rdAddr;
        for (int d = 0; d < 2; d++) begin
            modelStep(d);
            expQ.push_back(modelRec(d));
        end
        @(posedge clock);
        #1;
        o.hex = if0.hex; o.cursor = if0.cursor; o.full = if0.full;
        o.overflow = if0.overflow; o.busy = if0.busy; o.rd = if0.rd_data;
        e = expQ.pop_front();
        compareRec("w0", o, e);
        o.hex = if1.hex; o.cursor = if1.cursor; o.full = if1.full;
        o.overflow = if1.overflow; o.busy = if1.busy; o.rd = if1.rd_data;
        e = expQ.pop_front();
        compareRec("w1", o, e);
    endtask

    task automatic doIdle(input logic [2:0] rdAddr);
        applyStimulus(0, 3'd0, 8'h00, 0, 8'h00, 0, 0, rdAddr, 0);
    endtask
    task automatic doReset();
        applyStimulus(0, 3'd0, 8'h00, 0, 8'h00, 0, 0, 3'd0, 1);
    endtask
    task automatic doWrite(input logic [2:0] a, input logic [7:0] dat);
        applyStimulus(1, a, dat, 0, 8'h00, 0, 0, 3'd0, 0);
    endtask
    task automatic doPush(input logic [7:0] dat);
        applyStimulus(0, 3'd0, 8'h00, 1, dat, 0, 0, 3'd0, 0);
    endtask
    task automatic doBack();
        applyStimulus(0, 3'd0, 8'h00, 0, 8'h00, 1, 0, 3'd0, 0);
    endtask
    task automatic doClear();
        applyStimulus(0, 3'd0, 8'h00, 0, 8'h00, 0, 1, 3'd0, 0);
    endtask

    initial begin
        int busyCycles;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 8; i++) mMem[d][i] = 8'h00;
            mCursor[d] = 0; mOvf[d] = 0; mBusy[d] = 0; mSweep[d] = 0; mRd[d] = 0;
        end

        // 1: direct write and registered read-back
        doReset();
        doReset();
        checkOutput("t1_reset_hex", 64'(if0.hex), 64'h0);
        doWrite(3'd3, 8'hA5);
        checkOutput("t1_hex", 64'(if0.hex), 64'h00000000A5000000);
        doIdle(3'd3);
        checkOutput("t1_rd_data", 64'(if0.rd_data), 64'hA5);
        applyStimulus(1, 3'd3, 8'h5A, 0, 8'h00, 0, 0, 3'd3, 0);
        checkOutput("t1_rd_before_write", 64'(if0.rd_data), 64'hA5);

        // 2: fill, overflow, backspace out of full
        doReset();
        for (int i = 1; i <= 8; i++) doPush(8'(i * 8'h11));
        checkOutput("t2_hex_full", 64'(if0.hex), 64'h8877665544332211);
        checkOutput("t2_full", 64'(if0.full), 64'h1);
        doPush(8'h99);
        checkOutput("t2_hex_unchanged", 64'(if0.hex), 64'h8877665544332211);
        checkOutput("t2_overflow", 64'(if0.overflow), 64'h1);
        doBack();
        checkOutput("t2_hex_back", 64'(if0.hex), 64'h0077665544332211);
        checkOutput("t2_cursor_back", 64'(if0.cursor), 64'd7);

        // 3: wrap-around append and backspace from zero
        doReset();
        for (int i = 1; i <= 9; i++) doPush(8'(i));
        checkOutput("t3_entry0", 64'(if1.hex[7:0]), 64'h09);
        checkOutput("t3_cursor", 64'(if1.cursor), 64'd1);
        doBack();
        doBack();
        checkOutput("t3_cursor_wrapback", 64'(if1.cursor), 64'd7);
        checkOutput("t3_entry7", 64'(if1.hex[63:56]), 64'h00);

        // 4: clear sweep with a push during busy
        doReset();
        for (int i = 0; i < 9; i++) doPush(8'hFF);
        doClear();
        busyCycles = 0;
        for (int k = 0; k < 12; k++) begin
            if (if0.busy) busyCycles++;
            if (k == 1) doPush(8'h55);
            else        doIdle(3'(k));
        end
        checkOutput("t4_busy_cycles", 64'(busyCycles), 64'd8);
        checkOutput("t4_hex", 64'(if0.hex), 64'h0);
        checkOutput("t4_overflow", 64'(if0.overflow), 64'h0);

        // 5: priority between simultaneous commands
        doReset();
        applyStimulus(1, 3'd2, 8'h3C, 1, 8'h77, 0, 0, 3'd0, 0);
        checkOutput("t5_hex_prio", 64'(if0.hex), 64'h0000000000_3C0000);
        checkOutput("t5_cursor_prio", 64'(if0.cursor), 64'd0);
        doBack();
        applyStimulus(1, 3'd5, 8'hEE, 0, 8'h00, 0, 1, 3'd0, 0);
        for (int k = 0; k < 9; k++) doIdle(3'd5);
        checkOutput("t5_hex_after_clear", 64'(if0.hex), 64'h0);

        // 6: reset aborts a sweep
        for (int i = 0; i < 3; i++) doPush(8'hAB);
        doClear();
        for (int k = 0; k < 3; k++) doIdle(3'd0);
        doReset();
        checkOutput("t6_busy", 64'(if0.busy), 64'h0);
        checkOutput("t6_hex", 64'(if0.hex), 64'h0);
        doPush(8'h42);
        checkOutput("t6_entry0", 64'(if0.hex), 64'h42);
        checkOutput("t6_cursor", 64'(if0.cursor), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/hex_display_buffer.md
Name: hex_display_buffer

Overview:
- Parametrised byte-addressed display buffer driving the hex/seven-segment and VGA text overlay paths.
- Supports direct addressed writes, plus a cursor mode for keyboard-style entry: append at cursor, backspace, and a multi-cycle clear sweep.
- Sits between the PS/2 scan-code decoder and the display drivers; the full buffer is exposed flat on `hex`.
- Registered read-back port provided for debug and overlay use.

Parameters:
- DATA_WIDTH, 8, bits per entry.
- DEPTH, 8, number of entries (need not be a power of two, minimum 2).
- ADDR_WIDTH, 3, entry address width; must satisfy 2^ADDR_WIDTH >= DEPTH.
- WRAP, 0, cursor behaviour at end of buffer: 0 = saturate and report full; 1 = wrap around.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- wr_en  in  1  direct write strobe.
- wr_addr  in  ADDR_WIDTH  direct write entry index.
- wr_data  in  DATA_WIDTH  direct write data.
- push  in  1  append push_data at cursor, then advance cursor.
- push_data  in  DATA_WIDTH  append data.
- backspace  in  1  retreat cursor and zero that entry.
- clear  in  1  start clear sweep.
- rd_addr  in  ADDR_WIDTH  read-back index.
- rd_data  out  DATA_WIDTH  registered read-back data.
- cursor  out  ADDR_WIDTH+1  current cursor, range 0..DEPTH.
- full  out  1  cursor == DEPTH (only possible when WRAP=0).
- overflow  out  1  sticky flag: a push was dropped while full.
- busy  out  1  clear sweep in progress.
- hex  out  DEPTH*DATA_WIDTH  flat buffer; entry i at bits [i*DATA_WIDTH +: DATA_WIDTH].

Behaviour:
- Reset is synchronous, active-high, on clock. It sets all entries, rd_data, cursor, overflow and busy to 0, and the FSM to IDLE.
- Reset mid-sweep aborts the sweep immediately.
- FSM has two states: IDLE and CLEARING.
- Command priority in IDLE, one action per cycle:
  - clear > wr_en > push > backspace.
  - Lower-priority strobes asserted in the same cycle are dropped, with no side effects.
- clear:
  - IDLE -> CLEARING.
  - cursor and overflow go to 0 on that same edge.
  - The sweep zeroes entry k on the k-th cycle in CLEARING, for k = 0..DEPTH-1.
  - Return to IDLE after entry DEPTH-1 is zeroed.
  - busy is high for exactly DEPTH cycles, starting the cycle after clear is sampled.
- While busy, all of wr_en, push, backspace and clear are ignored. Entries not yet swept retain their old value on `hex` until reached.
- wr_en:
  - Writes entry wr_addr on the next edge.
  - wr_addr >= DEPTH is ignored.
  - cursor is unaffected.
- push:
  - If full is set: entry writes are suppressed, overflow is set, and cursor is unchanged.
  - Otherwise: entry[cursor] <= push_data.
  - Cursor advance, WRAP=0: cursor <= cursor+1 (so it can reach DEPTH, which sets full).
  - Cursor advance, WRAP=1: cursor <= (cursor==DEPTH-1) ? 0 : cursor+1. full is never set.
- backspace:
  - If cursor > 0: cursor <= cursor-1 and entry[cursor-1] <= 0. This clears full if it was set.
  - If cursor == 0 and WRAP=0: no-op.
  - If cursor == 0 and WRAP=1: cursor <= DEPTH-1 and entry[DEPTH-1] <= 0.
- full is combinational from cursor; overflow is sticky until clear or reset.
- rd_data:
  - 1-cycle latency: rd_data <= entry[rd_addr] at each edge, reflecting contents before that edge's write.
  - rd_addr >= DEPTH returns 0.
- `hex` shows register contents directly, with no extra latency.
- Flag updates happen on the same edge as the triggering command.

Test Plan:
1. Reset; then wr_en, wr_addr=3, wr_data=0xA5 -> hex[31:24]=0xA5, all other bits 0, cursor=0. Next cycle rd_addr=3 -> rd_data=0xA5 one cycle later.
2. WRAP=0, DEPTH=8: push 0x11..0x88 on 8 consecutive cycles -> hex=0x8877665544332211, cursor=8, full=1. A 9th push of 0x99 -> hex unchanged, overflow=1. Then backspace -> entry7=0, cursor=7, full=0, overflow still 1.
3. WRAP=1: 9 pushes 0x01..0x09 -> entry0=0x09, cursor=1, full never 1. From cursor=0, backspace -> cursor=7, entry7=0.
4. Buffer filled with 0xFF, then clear -> busy high for exactly 8 cycles, entries zeroed in index order, one per cycle. A push during busy is ignored. After busy falls: hex=0, cursor=0, overflow=0.
5. Same-cycle wr_en(addr 2, 0x3C) + push(0x77) at cursor=0 -> entry2=0x3C, entry0 unchanged, cursor=0. Same-cycle clear + wr_en -> the clear sweep runs and the write is dropped.
6. Reset asserted during the 4th cycle of the clear sweep -> next cycle busy=0, hex=0, FSM IDLE. Then push 0x42 -> entry0=0x42, cursor=1.
